// File: rtl/dfr_readout_engine.sv
// dfr_readout_engine
// Owns the reservoir-state (X), weight (W) and output (Y) memories plus the
// run configuration registers. A start pulse computes, for every sample s,
//   Y[s] = sat32((sum_{n<N} W[n] * X[s*N+n]) >>> FRAC_BITS)
// through a read -> multiply -> accumulate pipeline.
// X_DEPTH, W_DEPTH and Y_DEPTH are expected to be powers of two so that the
// modulo addressing reduces to dropping upper index bits.
module dfr_readout_engine #(
  parameter int X_DEPTH   = 4096,
  parameter int W_DEPTH   = 64,
  parameter int Y_DEPTH   = 1024,
  parameter int FRAC_BITS = 8,
  parameter int ACC_W     = 48
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [3:0]  mem_sel,
  input  logic [15:0] mem_addr,
  input  logic        mem_wen,
  input  logic [31:0] mem_data_in,
  output logic [31:0] mem_data_out,
  output logic        busy,
  output logic        done
);

  localparam int XA = $clog2(X_DEPTH);
  localparam int WA = $clog2(W_DEPTH);
  localparam int YA = $clog2(Y_DEPTH);
  localparam int CW = WA + 1;  // node count 0..W_DEPTH
  localparam int SW = YA + 1;  // sample count 0..Y_DEPTH

  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-32){1'b0}}, 32'h7FFF_FFFF};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-32){1'b1}}, 32'h8000_0000};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_MAC   = 3'd2,
    S_DRAIN = 3'd3,
    S_WRITE = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  // Shift the accumulator down to the output scale and clamp to signed 32 bits.
  function automatic logic [31:0] sat32(input logic signed [ACC_W-1:0] v);
    logic signed [ACC_W-1:0] sh;
    sh = v >>> FRAC_BITS;
    if (sh > SAT_MAX)      return 32'h7FFF_FFFF;
    else if (sh < SAT_MIN) return 32'h8000_0000;
    else                   return sh[31:0];
  endfunction

  // Storage
  logic [31:0] r_xmem [X_DEPTH];
  logic [31:0] r_wmem [W_DEPTH];
  logic [31:0] r_ymem [Y_DEPTH];

  // Configuration / status registers
  logic [31:0] r_num_samples;
  logic [31:0] r_num_nodes;
  logic [31:0] r_cyc_last;

  // Run control
  state_t            r_state;
  logic [CW-1:0]     r_nn;      // clamped node count N
  logic [SW-1:0]     r_ss;      // clamped sample count S
  logic [CW-1:0]     r_n;
  logic [SW-1:0]     r_s;
  logic [XA-1:0]     r_base;    // s*N modulo X_DEPTH
  logic              r_drain;
  logic [31:0]       r_cyc;
  logic signed [ACC_W-1:0] r_acc;

  // Datapath pipeline
  logic [15:0]        r_x_q;
  logic [15:0]        r_w_q;
  logic               r_rd_vld;
  logic signed [31:0] r_prod;
  logic               r_prod_vld;

  // Combinational helpers
  logic [13:0]   w_idx;
  logic          w_cfg_we;
  logic [CW-1:0] w_n_clamp;
  logic [SW-1:0] w_s_clamp;
  logic [XA-1:0] w_x_rd_addr;
  logic [31:0]   w_rd_data;
  logic signed [ACC_W-1:0] w_prod_ext;
  logic          w_unused;

  assign w_idx       = mem_addr[15:2];
  assign w_cfg_we    = mem_wen & ~busy;
  assign w_n_clamp   = (r_num_nodes > 32'(W_DEPTH))   ? CW'(W_DEPTH) : r_num_nodes[CW-1:0];
  assign w_s_clamp   = (r_num_samples > 32'(Y_DEPTH)) ? SW'(Y_DEPTH) : r_num_samples[SW-1:0];
  assign w_x_rd_addr = r_base + XA'(r_n);
  assign w_prod_ext  = {{(ACC_W-32){r_prod[31]}}, r_prod};
  assign w_unused    = &{1'b0, mem_addr[1:0]};

  // Config-side read mux; any unmapped select or register reads as zero.
  always_comb begin
    w_rd_data = 32'd0;
    case (mem_sel)
      4'd0: w_rd_data = r_xmem[w_idx[XA-1:0]];
      4'd1: w_rd_data = r_wmem[w_idx[WA-1:0]];
      4'd2: w_rd_data = r_ymem[w_idx[YA-1:0]];
      4'd3: begin
        case (w_idx)
          14'd0:   w_rd_data = r_num_samples;
          14'd1:   w_rd_data = r_num_nodes;
          14'd2:   w_rd_data = r_cyc_last;
          default: w_rd_data = 32'd0;
        endcase
      end
      default: w_rd_data = 32'd0;
    endcase
  end

  // Registered config-side read data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) mem_data_out <= 32'd0;
    else     mem_data_out <= w_rd_data;
  end

  // X and W memories: config writes, plus the datapath operand read during MAC.
  always_ff @(posedge clk) begin
    if (w_cfg_we && mem_sel == 4'd0) r_xmem[w_idx[XA-1:0]] <= mem_data_in;
    if (w_cfg_we && mem_sel == 4'd1) r_wmem[w_idx[WA-1:0]] <= mem_data_in;
    if (r_state == S_MAC) begin
      r_x_q <= r_xmem[w_x_rd_addr][15:0];
      r_w_q <= r_wmem[r_n[WA-1:0]][15:0];
    end
  end

  // Y memory: written by the engine in WRITE, by the config side otherwise.
  always_ff @(posedge clk) begin
    if (r_state == S_WRITE)                r_ymem[r_s[YA-1:0]] <= sat32(r_acc);
    else if (w_cfg_we && mem_sel == 4'd2)  r_ymem[w_idx[YA-1:0]] <= mem_data_in;
  end

  // Signed 16x16 product register; only consumed when r_prod_vld is set.
  always_ff @(posedge clk) begin
    r_prod <= $signed(r_x_q) * $signed(r_w_q);
  end

  // Pipeline valid flags track which stages hold live MAC data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_vld   <= 1'b0;
      r_prod_vld <= 1'b0;
    end else begin
      r_rd_vld   <= (r_state == S_MAC);
      r_prod_vld <= r_rd_vld;
    end
  end

  // Run configuration registers (writable only while idle).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_num_samples <= 32'd0;
      r_num_nodes   <= 32'd0;
    end else if (w_cfg_we && mem_sel == 4'd3) begin
      if (w_idx == 14'd0) r_num_samples <= mem_data_in;
      if (w_idx == 14'd1) r_num_nodes   <= mem_data_in;
    end
  end

  // Run sequencer: IDLE -> LOAD -> (MAC -> DRAIN -> WRITE)*S -> DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      r_nn       <= '0;
      r_ss       <= '0;
      r_n        <= '0;
      r_s        <= '0;
      r_base     <= '0;
      r_drain    <= 1'b0;
      r_cyc      <= 32'd0;
      r_cyc_last <= 32'd0;
      r_acc      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_LOAD;
            busy    <= 1'b1;
            r_cyc   <= 32'd1;
          end
        end
        S_LOAD: begin
          r_cyc   <= r_cyc + 32'd1;
          r_nn    <= w_n_clamp;
          r_ss    <= w_s_clamp;
          r_n     <= '0;
          r_s     <= '0;
          r_base  <= '0;
          r_acc   <= '0;
          r_drain <= 1'b0;
          if (w_s_clamp == '0) begin
            r_state <= S_DONE;
            done    <= 1'b1;
          end else if (w_n_clamp == '0) begin
            r_state <= S_DRAIN;
          end else begin
            r_state <= S_MAC;
          end
        end
        S_MAC: begin
          r_cyc <= r_cyc + 32'd1;
          r_n   <= r_n + CW'(1);
          if (r_prod_vld) r_acc <= r_acc + w_prod_ext;
          if (r_n == r_nn - CW'(1)) begin
            r_state <= S_DRAIN;
            r_drain <= 1'b0;
          end
        end
        S_DRAIN: begin
          r_cyc   <= r_cyc + 32'd1;
          r_drain <= ~r_drain;
          if (r_prod_vld) r_acc <= r_acc + w_prod_ext;
          if (r_drain) r_state <= S_WRITE;
        end
        S_WRITE: begin
          r_cyc  <= r_cyc + 32'd1;
          r_acc  <= '0;
          r_base <= r_base + XA'(r_nn);
          r_s    <= r_s + SW'(1);
          r_n    <= '0;
          if (r_s == r_ss - SW'(1)) begin
            r_state <= S_DONE;
            done    <= 1'b1;
          end else if (r_nn == '0) begin
            r_state <= S_DRAIN;
          end else begin
            r_state <= S_MAC;
          end
        end
        S_DONE: begin
          r_cyc_last <= r_cyc;
          done       <= 1'b0;
          busy       <= 1'b0;
          r_state    <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dfr_readout_engine.sv
// Directed self-checking bench for dfr_readout_engine. A second instance with
// FRAC_BITS=0 shares all inputs and is used for the saturation cases.
module tb_dfr_readout_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  mem_sel = 4'd0;
  logic [15:0] mem_addr = 16'd0;
  logic        mem_wen = 1'b0;
  logic [31:0] mem_data_in = 32'd0;
  logic [31:0] mem_data_out, mem_data_out0;
  logic        busy, done, busy0, done0;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  dfr_readout_engine u_dut (
    .clk(clk), .rst(rst), .start(start), .mem_sel(mem_sel), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_data_in(mem_data_in), .mem_data_out(mem_data_out),
    .busy(busy), .done(done)
  );

  dfr_readout_engine #(.FRAC_BITS(0)) u_dut0 (
    .clk(clk), .rst(rst), .start(start), .mem_sel(mem_sel), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_data_in(mem_data_in), .mem_data_out(mem_data_out0),
    .busy(busy0), .done(done0)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%h expected=0x%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [3:0] sel, input int idx, input logic [31:0] d);
    mem_sel = sel; mem_addr = {14'(idx), 2'b00}; mem_data_in = d; mem_wen = 1'b1;
    @(posedge clk); #1;
    mem_wen = 1'b0;
  endtask

  // Push the expected word, apply the address, compare one cycle later.
  task automatic rd(input string tag, input logic [3:0] sel, input int idx,
                    input logic [31:0] exp, input bit alt);
    logic [31:0] e;
    exp_q.push_back(exp);
    mem_sel = sel; mem_addr = {14'(idx), 2'b01};
    @(posedge clk); #1;
    e = exp_q.pop_front();
    if (alt) chk(tag, mem_data_out0, e);
    else     chk(tag, mem_data_out, e);
  endtask

  // Pulse start (caller may have set up a coincident write), then count busy
  // cycles and done pulses. poke_at: busy cycle at which X[0]=99 and a second
  // start are attempted. rst_at: busy cycle at which reset is asserted.
  task automatic run(input int poke_at, input int rst_at, output int bc, output int dn);
    bit ended;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; mem_wen = 1'b0;
    bc = 0; dn = 0; ended = 1'b0;
    for (int k = 0; k < 5000; k++) begin
      if (busy) bc++;
      if (done) dn++;
      if (!busy) begin ended = 1'b1; break; end
      if (bc == poke_at) begin
        mem_sel = 4'd0; mem_addr = 16'd0; mem_data_in = 32'd99; mem_wen = 1'b1; start = 1'b1;
      end else begin
        mem_wen = 1'b0; start = 1'b0;
      end
      if (bc == rst_at) begin
        rst = 1'b1; #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        rst = 1'b0; ended = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!ended) chk("run_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int bc, dn;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_rdata", mem_data_out, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    rd("reset_nsamp", 4'd3, 0, 32'd0, 1'b0);
    rd("reset_nnode", 4'd3, 1, 32'd0, 1'b0);

    // Config register writes and readback
    wr(4'd3, 0, 32'd2);
    wr(4'd3, 1, 32'd4);
    rd("cfg_nsamp", 4'd3, 0, 32'd2, 1'b0);
    rd("cfg_nnode", 4'd3, 1, 32'd4, 1'b0);
    rd("unmapped_sel", 4'd7, 0, 32'd0, 1'b0);

    // Single run
    for (int i = 0; i < 4; i++) wr(4'd1, i, 32'(256 * (i + 1)));
    for (int i = 0; i < 8; i++) wr(4'd0, i, (i < 4) ? 32'd1 : 32'd2);
    run(-1, -1, bc, dn);
    chk("run_busy", 32'(bc), 32'd16);
    chk("run_done", 32'(dn), 32'd1);
    rd("run_y0", 4'd2, 0, 32'd10, 1'b0);
    rd("run_y1", 4'd2, 1, 32'd20, 1'b0);
    rd("run_cyc", 4'd3, 2, 32'd16, 1'b0);

    // Writes and start while busy are dropped
    wr(4'd2, 0, 32'd0);
    wr(4'd2, 1, 32'd0);
    run(3, -1, bc, dn);
    chk("busy_rule_busy", 32'(bc), 32'd16);
    chk("busy_rule_done", 32'(dn), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("busy_rule_norerun", 32'(busy), 32'd0);
    rd("busy_rule_x0", 4'd0, 0, 32'd1, 1'b0);
    rd("busy_rule_y0", 4'd2, 0, 32'd10, 1'b0);
    rd("busy_rule_y1", 4'd2, 1, 32'd20, 1'b0);

    // Reset in the 5th MAC cycle (busy cycle 9), then a clean restart
    wr(4'd2, 0, 32'd0);
    wr(4'd2, 1, 32'd0);
    run(-1, 9, bc, dn);
    @(posedge clk); #1;
    rd("midrst_y0_kept", 4'd2, 0, 32'd10, 1'b0);
    rd("midrst_y1_unwritten", 4'd2, 1, 32'd0, 1'b0);
    rd("midrst_nsamp", 4'd3, 0, 32'd0, 1'b0);
    wr(4'd3, 0, 32'd2);
    wr(4'd3, 1, 32'd4);
    run(-1, -1, bc, dn);
    chk("restart_busy", 32'(bc), 32'd16);
    rd("restart_y1", 4'd2, 1, 32'd20, 1'b0);
    rd("restart_cyc", 4'd3, 2, 32'd16, 1'b0);

    // S=0 with the num_samples write landing in the start cycle
    wr(4'd2, 0, 32'h55);
    mem_sel = 4'd3; mem_addr = 16'd0; mem_data_in = 32'd0; mem_wen = 1'b1;
    run(-1, -1, bc, dn);
    chk("s0_busy", 32'(bc), 32'd2);
    chk("s0_done", 32'(dn), 32'd1);
    rd("s0_y0", 4'd2, 0, 32'h55, 1'b0);
    rd("s0_cyc", 4'd3, 2, 32'd2, 1'b0);

    // N=0, S=3
    for (int i = 0; i < 3; i++) wr(4'd2, i, 32'd7);
    wr(4'd3, 1, 32'd0);
    wr(4'd3, 0, 32'd3);
    run(-1, -1, bc, dn);
    chk("n0_busy", 32'(bc), 32'd11);
    for (int i = 0; i < 3; i++) rd($sformatf("n0_y%0d", i), 4'd2, i, 32'd0, 1'b0);

    // Most negative operands; upper 16 bits of the stored word are not used
    wr(4'd1, 0, 32'h0000_8000);
    wr(4'd0, 0, 32'h1234_8000);
    wr(4'd3, 1, 32'd1);
    wr(4'd3, 0, 32'd1);
    run(-1, -1, bc, dn);
    chk("neg_busy", 32'(bc), 32'd6);
    rd("neg_y0", 4'd2, 0, 32'h0040_0000, 1'b0);
    rd("neg_x0_full", 4'd0, 0, 32'h1234_8000, 1'b0);

    // Positive overflow: 64 products of 2^30
    for (int i = 0; i < 64; i++) begin
      wr(4'd1, i, 32'h8000);
      wr(4'd0, i, 32'h8000);
    end
    wr(4'd3, 1, 32'd64);
    run(-1, -1, bc, dn);
    chk("ovf_busy", 32'(bc), 32'd69);
    rd("ovf_y0_frac8", 4'd2, 0, 32'h1000_0000, 1'b0);
    rd("ovf_y0_frac0", 4'd2, 0, 32'h7FFF_FFFF, 1'b1);

    // Negative overflow, with num_nodes above W_DEPTH clamped to 64
    for (int i = 0; i < 64; i++) wr(4'd1, i, 32'h7FFF);
    wr(4'd3, 1, 32'd100);
    run(-1, -1, bc, dn);
    chk("unf_busy", 32'(bc), 32'd69);
    rd("unf_y0_frac8", 4'd2, 0, 32'hF000_2000, 1'b0);
    rd("unf_y0_frac0", 4'd2, 0, 32'h8000_0000, 1'b1);
    rd("unf_nnode", 4'd3, 1, 32'd100, 1'b0);
    rd("unf_cyc", 4'd3, 2, 32'd69, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
